// File: rtl/sfx_mixer.sv
// CODEC sequencer that mixes music with a falling-pitch shot tone and a decaying noise hit.
// Optional SFX_DUCK_EN: music is attenuated a further 6 dB while either effect is active.
module sfx_mixer #(
  parameter int                          SAMPLE_W  = 24,
  parameter logic signed [SAMPLE_W-1:0]  SFX_AMP   = 24'sd1_000_000,
  parameter int                          SHOOT_LEN = 1024,
  parameter int                          SHOOT_HP0 = 8,
  parameter int                          HIT_LEN   = 2048
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       read_ready,
  input  logic                       write_ready,
  output logic                       read,
  output logic                       write,
  output logic                       music_en,
  input  logic signed [SAMPLE_W-1:0] note,
  input  logic                       shoot_evt,
  input  logic                       hit_evt,
  output logic signed [SAMPLE_W-1:0] writedata_left,
  output logic signed [SAMPLE_W-1:0] writedata_right
);

  localparam int SW    = $clog2(SHOOT_LEN + 1);
  localparam int HW    = $clog2(HIT_LEN + 1);
  localparam int SUM_W = SAMPLE_W + 2;

  localparam logic [SW-1:0] SH_LEN_C  = SW'(SHOOT_LEN);
  localparam logic [HW-1:0] HIT_LEN_C = HW'(HIT_LEN);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(SAMPLE_W-1){1'b0}}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_MIX   = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  logic [1:0]                r_state, w_state_nx;
  logic                      r_shoot_q, r_hit_q, r_sh_pend, r_hit_pend;
  logic                      r_sh_on, r_sh_ph, r_hit_on;
  logic [SW-1:0]             r_sh_el;
  logic [15:0]               r_sh_cnt;
  logic [HW-1:0]             r_hit_el;
  logic [15:0]               r_lfsr;
  logic signed [SAMPLE_W-1:0] r_out;

  logic                      w_mix, w_sh_on, w_sh_ph, w_hit_on;
  logic [SW-1:0]             w_sh_el;
  logic [15:0]               w_sh_cnt, w_sh_hp, w_lfsr_nx;
  logic [HW-1:0]             w_hit_el;
  logic signed [SAMPLE_W-1:0] w_sh_val, w_hit_mag, w_hit_val, w_music, w_sat;
  logic signed [SUM_W-1:0]   w_sum;

  assign w_mix = (r_state == ST_MIX);

  // A pending trigger restarts the effect in the very sample being mixed.
  assign w_sh_on  = r_sh_pend | r_sh_on;
  assign w_sh_el  = r_sh_pend ? '0 : r_sh_el;
  assign w_sh_cnt = r_sh_pend ? '0 : r_sh_cnt;
  assign w_sh_ph  = r_sh_pend ? 1'b1 : r_sh_ph;
  assign w_sh_hp  = 16'(SHOOT_HP0) + 16'(w_sh_el >> 6);
  assign w_sh_val = !w_sh_on ? '0 : (w_sh_ph ? SFX_AMP : -SFX_AMP);

  assign w_hit_on  = r_hit_pend | r_hit_on;
  assign w_hit_el  = r_hit_pend ? '0 : r_hit_el;
  assign w_hit_mag = SFX_AMP >>> (w_hit_el >> 9);
  assign w_hit_val = !w_hit_on ? '0 : (r_lfsr[0] ? -w_hit_mag : w_hit_mag);

  assign w_lfsr_nx = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

`ifdef SFX_DUCK_EN
  assign w_music = (w_sh_on || w_hit_on) ? (note >>> 2) : (note >>> 1);
`else
  assign w_music = note >>> 1;
`endif

  assign w_sum = {{2{w_music[SAMPLE_W-1]}}, w_music}
               + {{2{w_sh_val[SAMPLE_W-1]}}, w_sh_val}
               + {{2{w_hit_val[SAMPLE_W-1]}}, w_hit_val};

  always_comb begin
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX[SAMPLE_W-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      w_sat = w_sum[SAMPLE_W-1:0];
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (read_ready && write_ready) w_state_nx = ST_FETCH;
      ST_FETCH: w_state_nx = ST_MIX;
      ST_MIX:   w_state_nx = ST_WRITE;
      ST_WRITE: if (write_ready) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  assign read            = (r_state == ST_FETCH);
  assign music_en        = (r_state == ST_FETCH);
  assign write           = (r_state == ST_WRITE) && write_ready;
  assign writedata_left  = r_out;
  assign writedata_right = r_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_shoot_q  <= 1'b0;
      r_hit_q    <= 1'b0;
      r_sh_pend  <= 1'b0;
      r_hit_pend <= 1'b0;
      r_sh_on    <= 1'b0;
      r_sh_ph    <= 1'b0;
      r_sh_el    <= '0;
      r_sh_cnt   <= '0;
      r_hit_on   <= 1'b0;
      r_hit_el   <= '0;
      r_lfsr     <= 16'hACE1;
      r_out      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_shoot_q  <= shoot_evt;
      r_hit_q    <= hit_evt;
      r_sh_pend  <= (shoot_evt & ~r_shoot_q) | (r_sh_pend & ~w_mix);
      r_hit_pend <= (hit_evt & ~r_hit_q) | (r_hit_pend & ~w_mix);
      if (w_mix) begin
        r_out  <= w_sat;
        r_lfsr <= w_lfsr_nx;
        if (w_sh_on) begin
          r_sh_el <= w_sh_el + SW'(1);
          r_sh_on <= (w_sh_el + SW'(1)) != SH_LEN_C;
          if (w_sh_cnt == w_sh_hp - 16'd1) begin
            r_sh_cnt <= '0;
            r_sh_ph  <= ~w_sh_ph;
          end else begin
            r_sh_cnt <= w_sh_cnt + 16'd1;
            r_sh_ph  <= w_sh_ph;
          end
        end
        if (w_hit_on) begin
          r_hit_el <= w_hit_el + HW'(1);
          r_hit_on <= (w_hit_el + HW'(1)) != HIT_LEN_C;
        end
      end
    end
  end

endmodule
